// File: rtl/fir_pkg.sv
// Shared types and sizing for the FIR coefficient configuration controller.
package fir_pkg;
    localparam int NTAPS = 16;
    localparam int CW    = 16;
    localparam int CNTW  = $clog2(NTAPS);

    typedef logic signed [CW-1:0] coef_t;

    typedef enum logic [1:0] {IDLE, LOAD, ARMED, SWAP} fir_cfg_state_e;
endpackage

// File: rtl/fir_coef_ctrl_if.sv
// Coefficient stream port: host (master) pushes words, controller (slave) accepts.
// A word transfers only at a rising edge where cfg_valid and cfg_ready are both high.
interface fir_coef_ctrl_if;
    import fir_pkg::*;

    logic  cfg_valid;
    logic  cfg_ready;
    logic  cfg_last;
    coef_t cfg_data;

    modport master (output cfg_valid, cfg_data, cfg_last, input cfg_ready);
    modport slave  (input cfg_valid, cfg_data, cfg_last, output cfg_ready);
endinterface

// File: rtl/coef_bank.sv
// NTAPS x CW coefficient register file with one write port and a flat read-out.
module coef_bank
    import fir_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [CNTW-1:0]       addr_i,
    input  coef_t                 data_i,
    output logic [NTAPS*CW-1:0]   flat_o
);

    coef_t mem_q [NTAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) mem_q[k] <= '0;
        end else if (we_i) begin
            mem_q[addr_i] <= data_i;
        end
    end

    always_comb begin
        flat_o = '0;
        for (int k = 0; k < NTAPS; k++) flat_o[k*CW +: CW] = mem_q[k];
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Double-buffered FIR coefficient controller: loads a shadow bank from the
// config stream and swaps it in atomically on a sample boundary.
module fir_coef_ctrl
    import fir_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    fir_coef_ctrl_if.slave        cfg,
    input  logic                  sample_tick,
    input  logic                  err_clr,
    output logic [NTAPS*CW-1:0]   coef_flat,
    output logic                  bank_sel,
    output logic                  swap_pulse,
    output logic                  busy,
    output logic                  cfg_err,
    output fir_cfg_state_e        dbg_state
);

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NTAPS - 1);

    fir_cfg_state_e        state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic                  bank_sel_q, bank_sel_d;
    logic                  swap_pulse_q, swap_pulse_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  ready_q, ready_d;
    logic [NTAPS*CW-1:0]   coef_q, coef_d;
    logic [NTAPS*CW-1:0]   flat0, flat1, shadow_flat;
    logic                  hs, wr_en, err_set;

    assign hs = cfg.cfg_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (cfg.cfg_last) begin
                        err_set = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        cnt_d   = CNTW'(1);
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (hs) begin
                    if (cnt_q == LAST_IDX && cfg.cfg_last) begin
                        wr_en   = 1'b1;
                        cnt_d   = '0;
                        state_d = ARMED;
                    end else if (cnt_q == LAST_IDX || cfg.cfg_last) begin
                        err_set = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ARMED: if (sample_tick) state_d = SWAP;
            SWAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is registered from the next state so it stays low while in reset.
    assign ready_d      = (state_d == IDLE) || (state_d == LOAD);
    assign swap_pulse_d = (state_q == SWAP);
    assign bank_sel_d   = (state_q == SWAP) ? ~bank_sel_q : bank_sel_q;
    assign coef_d       = (state_q == SWAP) ? shadow_flat : coef_q;
    assign cfg_err_d    = err_set | (cfg_err_q & ~err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bank_sel_q   <= 1'b0;
            swap_pulse_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            ready_q      <= 1'b0;
            coef_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bank_sel_q   <= bank_sel_d;
            swap_pulse_q <= swap_pulse_d;
            cfg_err_q    <= cfg_err_d;
            ready_q      <= ready_d;
            coef_q       <= coef_d;
        end
    end

    // The shadow bank is always the one not currently selected as active.
    coef_bank u_bank0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (wr_en && bank_sel_q),
        .addr_i (cnt_q),
        .data_i (cfg.cfg_data),
        .flat_o (flat0)
    );

    coef_bank u_bank1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (wr_en && !bank_sel_q),
        .addr_i (cnt_q),
        .data_i (cfg.cfg_data),
        .flat_o (flat1)
    );

    assign shadow_flat   = bank_sel_q ? flat0 : flat1;
    assign cfg.cfg_ready = ready_q;
    assign coef_flat     = coef_q;
    assign bank_sel      = bank_sel_q;
    assign swap_pulse    = swap_pulse_q;
    assign busy          = (state_q == LOAD) || (state_q == ARMED);
    assign cfg_err       = cfg_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: table of coefficient sets plus reset/hold sequences.
module tb_fir_coef_ctrl;
  import fir_pkg::*;

  localparam int FW = NTAPS * CW;

  logic clk;
  logic rst_n;
  logic sample_tick;
  logic err_clr;
  logic [FW-1:0] coef_flat;
  logic bank_sel;
  logic swap_pulse;
  logic busy;
  logic cfg_err;
  fir_cfg_state_e dbg_state;

  fir_coef_ctrl_if cfg_if ();

  fir_coef_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_if.slave),
    .sample_tick (sample_tick),
    .err_clr     (err_clr),
    .coef_flat   (coef_flat),
    .bank_sel    (bank_sel),
    .swap_pulse  (swap_pulse),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [CW-1:0] exp_q[$];
  logic [FW-1:0] exp_flat;
  logic          exp_bank;
  int            n_cmp;
  int            n_err;

  typedef struct {
    int n;
    int last_at;
    int base;
    bit gaps;
    bit exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // driver tasks; all start and end at posedge+1
  task automatic send_word(input logic [CW-1:0] d, input bit last, input bit gaps);
    int t;
    if (gaps && $urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = d;
    cfg_if.cfg_last  = last;
    t = 0;
    while (!cfg_if.cfg_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) check("ready_timeout", FW'(cfg_if.cfg_ready), FW'(1));
    @(posedge clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
  endtask

  task automatic send_set(input int n, input int last_at, input int base, input bit gaps);
    logic [CW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = CW'(base + i);
      exp_q.push_back(d);
      send_word(d, (i == last_at), gaps);
    end
  endtask

  task automatic finish_err();
    check("err_set", FW'(cfg_err), FW'(1));
    check("err_state", FW'(dbg_state), FW'(IDLE));
    check("err_coef", coef_flat, exp_flat);
    exp_q.delete();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clr", FW'(cfg_err), FW'(0));
  endtask

  task automatic finish_swap(input int hold);
    check("armed_state", FW'(dbg_state), FW'(ARMED));
    check("armed_busy", FW'(busy), FW'(1));
    check("armed_ready", FW'(cfg_if.cfg_ready), FW'(0));
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      check("hold_coef", coef_flat, exp_flat);
      check("hold_busy_ready", FW'({busy, cfg_if.cfg_ready}), FW'(2'b10));
    end
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    check("swap_state", FW'(dbg_state), FW'(SWAP));
    check("pulse_early", FW'(swap_pulse), FW'(0));
    check("coef_early", coef_flat, exp_flat);
    @(posedge clk);
    #1;
    for (int k = 0; k < NTAPS; k++) begin
      if (exp_q.size() > 0) exp_flat[k*CW +: CW] = exp_q.pop_front();
      else exp_flat[k*CW +: CW] = 'x;
    end
    exp_bank = ~exp_bank;
    check("swap_pulse", FW'(swap_pulse), FW'(1));
    check("bank_sel", FW'(bank_sel), FW'(exp_bank));
    for (int k = 0; k < NTAPS; k++)
      check($sformatf("tap%0d", k), FW'(coef_flat[k*CW +: CW]), FW'(exp_flat[k*CW +: CW]));
    @(posedge clk);
    #1;
    check("pulse_single", FW'(swap_pulse), FW'(0));
    check("post_state", FW'(dbg_state), FW'(IDLE));
    check("post_coef", coef_flat, exp_flat);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_coef"}, coef_flat, FW'(0));
    check({tag, "_outs"}, FW'({bank_sel, cfg_if.cfg_ready, swap_pulse, busy, cfg_err}), FW'(0));
    check({tag, "_state"}, FW'(dbg_state), FW'(IDLE));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    exp_q.delete();
    exp_flat = '0;
    exp_bank = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                 n   last base    gaps err
    vecs[0] = '{16, 15,      1,  1'b0, 1'b0};
    vecs[1] = '{ 5,  4,    100,  1'b0, 1'b1};
    vecs[2] = '{16, -1,    200,  1'b0, 1'b1};
    vecs[3] = '{16, 15,    300,  1'b0, 1'b0};
    vecs[4] = '{16, 15,    -10,  1'b1, 1'b0};
    vecs[5] = '{ 1,  0,      7,  1'b0, 1'b1};
    vecs[6] = '{16, 15, -32768,  1'b1, 1'b0};

    n_cmp = 0;
    n_err = 0;
    exp_flat = '0;
    exp_bank = 1'b0;
    rst_n = 1'b0;
    sample_tick = 1'b0;
    err_clr = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
    cfg_if.cfg_data  = '0;

    #3;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", FW'(cfg_if.cfg_ready), FW'(1));

    for (int v = 0; v < 7; v++) begin
      send_set(vecs[v].n, vecs[v].last_at, vecs[v].base, vecs[v].gaps);
      if (vecs[v].exp_err) finish_err();
      else finish_swap(0);
    end

    // long wait in ARMED, then sample_tick while idle is ignored
    send_set(16, 15, 1000, 1'b0);
    finish_swap(50);
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    check("idle_tick_state", FW'(dbg_state), FW'(IDLE));
    check("idle_tick_coef", coef_flat, exp_flat);

    // error and clear in the same cycle: error wins
    err_clr = 1'b1;
    send_word(16'h0005, 1'b1, 1'b0);
    check("err_over_clr", FW'(cfg_err), FW'(1));
    err_clr = 1'b0;
    finish_err();

    // reset mid-load and mid-armed
    send_set(8, -1, 2000, 1'b0);
    do_reset("rst_load");
    send_set(16, 15, 3000, 1'b0);
    check("pre_rst_armed", FW'(dbg_state), FW'(ARMED));
    do_reset("rst_armed");
    send_set(16, 15, 50, 1'b1);
    finish_swap(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
